toggle_event_decoder: RTL and testbench
=======================================

Name: toggle_event_decoder

Overview:
- Receive end of a toggle-encoded event line, the complement of the tflipflop block.
- A T flip-flop on the sending side flips its Q once per event. This block watches that Q level, turns each level change back into a one-cycle event, queues pending events in a saturating counter, and hands them to a consumer over a valid/ready handshake.
- It sits downstream of any tflipflop used as an event signal. It also counts total events for debug.

Parameters:
- SYNC_STAGES, 2, number of sampling flops on q_in (min 1).
- PEND_W, 3, width of the pending-event counter. Max queued events = 2^PEND_W - 1.
- CNT_W, 8, width of the total accepted-event counter. Wraps modulo 2^CNT_W.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- q_in  in  1  toggle line (Q of the sending T flip-flop).
- evt_ready  in  1  consumer accepts one event this cycle.
- evt_valid  out  1  at least one event pending.
- edge_pulse  out  1  one-cycle strobe per detected toggle, including dropped ones.
- pending  out  PEND_W  events queued, not yet consumed.
- evt_count  out  CNT_W  total accepted events, wrapping.
- overflow  out  1  sticky; an event was dropped because the queue was full.

Behaviour:
- Reset (synchronous, active-high):
  - Sampled on the rising edge of clk; wins over every other event in that cycle.
  - Clears all outputs to 0 (evt_valid, edge_pulse, pending, evt_count, overflow), the sync chain, and the stored level. State goes to PRIME.
  - Asserting rst mid-operation discards all queued events and clears overflow on that edge.
- Sampling:
  - q_in passes through SYNC_STAGES flops. s_q is the last stage.
  - lvl is the stored reference level.
- State machine:
  - PRIME:
    - Lasts SYNC_STAGES+1 cycles after reset release.
    - lvl <= s_q every cycle. No edges are counted, so a q_in already at 1 through reset creates no event.
    - Then go to RUN.
  - RUN:
    - An edge is detected when s_q != lvl.
    - On an edge: lvl <= s_q, and edge_pulse = 1 for exactly the next cycle (registered).
  - OVF:
    - Same as RUN, but overflow is held at 1.
    - Leaves OVF only via rst.
- Latency: a q_in change set up before clock edge k gives edge_pulse high in the cycle after edge k+SYNC_STAGES. pending updates on that same edge.
- Queue (evaluated each edge in RUN/OVF; pop = evt_valid & evt_ready):
  - Edge only, pending < max: pending+1, evt_count+1 (wraps).
  - Edge only, pending == max: pending unchanged, event dropped, evt_count unchanged, overflow <= 1, state -> OVF.
  - Pop only: pending-1.
  - Edge and pop together: pending unchanged and evt_count+1. Never overflows, even at max.
  - evt_ready while pending == 0: ignored; pending never underflows.
- evt_valid = (pending != 0), registered form, consistent with pending.
- Toggle rate: consecutive toggles must be at least 1 clk apart at s_q. Two flips that cancel before sampling are not detectable; this is a documented limitation and not checked.
- Widths: pending saturates, never wraps. evt_count wraps 2^CNT_W-1 -> 0 without affecting any flag.

Test Plan:
- Reset release with q_in = 1 held; no toggles for 10 cycles -> edge_pulse never asserts, pending = 0, evt_valid = 0.
- Three toggles of q_in 20 ns apart (10 ns clock), evt_ready = 0 -> three edge_pulse strobes, each 3 cycles after its toggle; pending = 3, evt_count = 3, evt_valid = 1.
- From pending = 3, evt_ready = 1 for 5 cycles -> pending steps 2, 1, 0, then holds 0; evt_valid drops after the third pop; no underflow.
- Eight toggles with evt_ready = 0 (PEND_W = 3) -> pending saturates at 7, 8th edge_pulse still strobes, evt_count = 7, overflow = 1 and stays 1. Then rst pulse -> all outputs 0.
- pending = 7 with a toggle arriving in the same cycle as evt_ready = 1 -> pending stays 7, evt_count increments, overflow stays 0.
- 260 toggles with evt_ready tied 1 (CNT_W = 8) -> evt_count wraps to 4; rst asserted mid-stream clears pending/evt_count on that edge and re-enters PRIME.

Source files
------------

// File: rtl/toggle_event_decoder.sv
// toggle_event_decoder: turns level changes on a T flip-flop Q line back into events,
// queues them in a saturating counter and hands them out over valid/ready.
`default_nettype none

module toggle_event_decoder #(
  parameter int SYNC_STAGES = 2,
  parameter int PEND_W      = 3,
  parameter int CNT_W       = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              q_in,
  input  logic              evt_ready,
  output logic              evt_valid,
  output logic              edge_pulse,
  output logic [PEND_W-1:0] pending,
  output logic [CNT_W-1:0]  evt_count,
  output logic              overflow
);

  localparam logic [PEND_W-1:0] PEND_MAX   = '1;
  localparam int                PC_W       = $clog2(SYNC_STAGES + 1) + 1;
  localparam logic [PC_W-1:0]   PRIME_LAST = PC_W'(SYNC_STAGES);

  typedef enum logic [1:0] {
    PRIME = 2'd0,
    RUN   = 2'd1,
    OVF   = 2'd2
  } state_t;

  state_t             state, state_n;
  logic [SYNC_STAGES-1:0] sync_q;
  logic               s_q;
  logic               lvl, lvl_n;
  logic [PC_W-1:0]    prime_cnt, prime_n;
  logic [PEND_W-1:0]  pend_n;
  logic [CNT_W-1:0]   cnt_n;
  logic               ovf_n;
  logic               pulse_n;
  logic               valid_n;
  logic               pop;
  logic               edge_det;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= q_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign s_q      = sync_q[SYNC_STAGES-1];
  assign pop      = evt_valid & evt_ready;
  // PRIME soaks up whatever level q_in held through reset, so it never counts as an edge
  assign edge_det = (state != PRIME) && (s_q != lvl);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= PRIME;
      lvl        <= 1'b0;
      prime_cnt  <= '0;
      pending    <= '0;
      evt_count  <= '0;
      overflow   <= 1'b0;
      edge_pulse <= 1'b0;
      evt_valid  <= 1'b0;
    end else begin
      state      <= state_n;
      lvl        <= lvl_n;
      prime_cnt  <= prime_n;
      pending    <= pend_n;
      evt_count  <= cnt_n;
      overflow   <= ovf_n;
      edge_pulse <= pulse_n;
      evt_valid  <= valid_n;
    end
  end

  always_comb begin
    state_n = state;
    lvl_n   = lvl;
    prime_n = prime_cnt;
    pend_n  = pending;
    cnt_n   = evt_count;
    ovf_n   = overflow;
    pulse_n = 1'b0;

    case (state)
      PRIME: begin
        lvl_n   = s_q;
        prime_n = prime_cnt + 1'b1;
        if (prime_cnt == PRIME_LAST) begin
          state_n = RUN;
        end
      end
      default: begin
        if (edge_det) begin
          lvl_n   = s_q;
          pulse_n = 1'b1;
        end
      end
    endcase

    // A pop in the same cycle frees a slot, so a simultaneous edge is never dropped
    if (edge_det && pop) begin
      cnt_n = evt_count + 1'b1;
    end else if (edge_det) begin
      if (pending == PEND_MAX) begin
        ovf_n   = 1'b1;
        state_n = OVF;
      end else begin
        pend_n = pending + 1'b1;
        cnt_n  = evt_count + 1'b1;
      end
    end else if (pop) begin
      pend_n = pending - 1'b1;
    end

    valid_n = (pend_n != '0);
  end

endmodule

`default_nettype wire

// File: tb/tb_toggle_event_decoder.sv
// Scoreboard bench for toggle_event_decoder: each toggle queues the expected strobe cycle and count.
`default_nettype none

module tb_toggle_event_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       q_in = 1'b0;
  logic       evt_ready = 1'b0;
  logic       evt_valid;
  logic       edge_pulse;
  logic [2:0] pending;
  logic [7:0] evt_count;
  logic       overflow;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  typedef struct {
    int         cyc;
    logic [7:0] cnt;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  toggle_event_decoder #(
    .SYNC_STAGES(2),
    .PEND_W(3),
    .CNT_W(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .q_in(q_in),
    .evt_ready(evt_ready),
    .evt_valid(evt_valid),
    .edge_pulse(edge_pulse),
    .pending(pending),
    .evt_count(evt_count),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Strobe monitor: every edge_pulse must match the oldest queued expectation
  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    if (!rst) begin
      if (edge_pulse) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pulse cyc=%0d evt_count=%0d, no strobe expected", cyc, evt_count);
        end else begin
          e = sb.pop_front();
          if (e.cyc !== cyc) begin
            errors++;
            $display("FAIL pulse_cycle got cyc=%0d expected cyc=%0d", cyc, e.cyc);
          end
          checks++;
          if (evt_count !== e.cnt) begin
            errors++;
            $display("FAIL pulse_count got %0d expected %0d at cyc=%0d", evt_count, e.cnt, cyc);
          end
        end
      end else if (sb.size() != 0 && sb[0].cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL missed_pulse got none expected at cyc=%0d (now %0d)", sb[0].cyc, cyc);
        void'(sb.pop_front());
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Toggle q_in now; strobe expected 3 cycles later with the given count
  task automatic toggle_push(input logic [7:0] c);
    exp_t x;
    q_in   = ~q_in;
    x.cyc  = cyc + 3;
    x.cnt  = c;
    sb.push_back(x);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    sb.delete();
    tick(2);
    rst = 1'b0;
    tick(5);
  endtask

  task automatic test_reset();
    q_in      = 1'b1;
    evt_ready = 1'b0;
    rst       = 1'b1;
    tick(3);
    checks++;
    if ({pending, evt_valid, evt_count, overflow, edge_pulse} !== 14'd0) begin
      errors++;
      $display("FAIL reset_outputs got p=%0d v=%0d c=%0d o=%0d e=%0d expected all 0",
               pending, evt_valid, evt_count, overflow, edge_pulse);
    end
    rst = 1'b0;
    tick(12);
    checks++;
    if (pending !== 3'd0 || evt_valid !== 1'b0) begin
      errors++;
      $display("FAIL prime_no_event got p=%0d v=%0d expected p=0 v=0", pending, evt_valid);
    end
  endtask

  task automatic test_toggles();
    evt_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      toggle_push(8'(i + 1));
      tick(2);
    end
    tick(4);
    checks++;
    if (pending !== 3'd3 || evt_count !== 8'd3 || evt_valid !== 1'b1) begin
      errors++;
      $display("FAIL three_toggles got p=%0d c=%0d v=%0d expected p=3 c=3 v=1",
               pending, evt_count, evt_valid);
    end
  endtask

  task automatic test_drain();
    int exp_p[5] = '{2, 1, 0, 0, 0};
    evt_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      checks++;
      if (pending !== 3'(exp_p[i]) || evt_valid !== (exp_p[i] != 0)) begin
        errors++;
        $display("FAIL drain_step%0d got p=%0d v=%0d expected p=%0d v=%0d",
                 i, pending, evt_valid, exp_p[i], exp_p[i] != 0);
      end
    end
    evt_ready = 1'b0;
    checks++;
    if (evt_count !== 8'd3) begin
      errors++;
      $display("FAIL drain_count got %0d expected 3", evt_count);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    evt_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      toggle_push(i < 7 ? 8'(i + 1) : 8'd7);
      tick(2);
    end
    tick(4);
    checks++;
    if (pending !== 3'd7 || evt_count !== 8'd7 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL saturate got p=%0d c=%0d o=%0d expected p=7 c=7 o=1",
               pending, evt_count, overflow);
    end
    tick(5);
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("FAIL overflow_sticky got %0d expected 1", overflow);
    end
    rst = 1'b1;
    sb.delete();
    tick(1);
    checks++;
    if ({pending, evt_valid, evt_count, overflow, edge_pulse} !== 14'd0) begin
      errors++;
      $display("FAIL ovf_reset got p=%0d v=%0d c=%0d o=%0d e=%0d expected all 0",
               pending, evt_valid, evt_count, overflow, edge_pulse);
    end
    rst = 1'b0;
    tick(5);
  endtask

  task automatic test_full_pop();
    evt_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      toggle_push(8'(i + 1));
      tick(2);
    end
    tick(4);
    checks++;
    if (pending !== 3'd7 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL full_setup got p=%0d o=%0d expected p=7 o=0", pending, overflow);
    end
    toggle_push(8'd8);
    tick(2);
    evt_ready = 1'b1;
    tick(1);
    evt_ready = 1'b0;
    checks++;
    if (pending !== 3'd7 || evt_count !== 8'd8 || overflow !== 1'b0 || evt_valid !== 1'b1) begin
      errors++;
      $display("FAIL edge_and_pop_full got p=%0d c=%0d o=%0d v=%0d expected p=7 c=8 o=0 v=1",
               pending, evt_count, overflow, evt_valid);
    end
    tick(3);
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL no_overflow_after got %0d expected 0", overflow);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    evt_ready = 1'b1;
    for (int i = 0; i < 260; i++) begin
      toggle_push(8'(i + 1));
      tick(2);
    end
    tick(4);
    checks++;
    if (evt_count !== 8'd4 || pending !== 3'd0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL count_wrap got c=%0d p=%0d o=%0d expected c=4 p=0 o=0",
               evt_count, pending, overflow);
    end
    evt_ready = 1'b0;
    toggle_push(8'd5);
    tick(4);
    checks++;
    if (pending !== 3'd1 || evt_count !== 8'd5) begin
      errors++;
      $display("FAIL pre_midreset got p=%0d c=%0d expected p=1 c=5", pending, evt_count);
    end
    q_in = ~q_in;
    tick(1);
    rst = 1'b1;
    sb.delete();
    tick(1);
    checks++;
    if (pending !== 3'd0 || evt_count !== 8'd0 || evt_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset got p=%0d c=%0d v=%0d expected all 0", pending, evt_count, evt_valid);
    end
    rst = 1'b0;
    tick(10);
    evt_ready = 1'b1;
    toggle_push(8'd1);
    tick(5);
    checks++;
    if (evt_count !== 8'd1 || pending !== 3'd0) begin
      errors++;
      $display("FAIL after_prime got c=%0d p=%0d expected c=1 p=0", evt_count, pending);
    end
    evt_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_toggles();
    test_drain();
    test_overflow();
    test_full_pop();
    test_wrap();
    tick(4);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d outstanding expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
